fpu_dp_div: RTL and testbench

FPU_DP_DIV -- requirements
Module: fpu_dp_div

---
 rtl/fpu_dp_div.sv | 251 +++++++++++++++++++++++++
 tb/tb_fpu_dp_div.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fpu_dp_div.sv
// fpu_dp_div -- multi-cycle IEEE-754 double-precision divider.
//
// Computes result = din1 / din2, rounded to nearest, ties to even, with a
// bit-serial restoring divider (one quotient bit per cycle). One operation
// is in flight at a time; requests arriving while busy are dropped.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   din1     dividend (IEEE double), captured with dval
//   din2     divisor  (IEEE double), captured with dval
//   dval     request strobe, sampled only while idle
//   result   quotient, held until the next completion
//   rdy      one-cycle pulse marking result valid
//   dz_flag  (FPU_DP_DIV_DZ_FLAG_EN only) finite nonzero / zero, valid with rdy
//
// Parameter QNAN: pattern returned for every invalid operation.
// Optional build macro: FPU_DP_DIV_DZ_FLAG_EN adds the dz_flag output.

module fpu_dp_div #(
  parameter logic [63:0] QNAN = 64'hFFF8_0000_0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] din1,
  input  logic [63:0] din2,
  input  logic        dval,
  output logic [63:0] result,
  output logic        rdy
`ifdef FPU_DP_DIV_DZ_FLAG_EN
  ,
  output logic        dz_flag
`endif
);

  localparam logic [3:0] WAIT_REQ      = 4'd0;
  localparam logic [3:0] UNPACK        = 4'd1;
  localparam logic [3:0] SPECIAL_CASES = 4'd2;
  localparam logic [3:0] NORMALISE_A   = 4'd3;
  localparam logic [3:0] NORMALISE_B   = 4'd4;
  localparam logic [3:0] DIV_INIT      = 4'd5;
  localparam logic [3:0] DIVIDE        = 4'd6;
  localparam logic [3:0] DIV_DONE      = 4'd7;
  localparam logic [3:0] NORMALISE_1   = 4'd8;
  localparam logic [3:0] NORMALISE_2   = 4'd9;
  localparam logic [3:0] ROUND         = 4'd10;
  localparam logic [3:0] PACK          = 4'd11;
  localparam logic [3:0] OUT_RDY       = 4'd12;

  localparam logic [6:0] LAST_STEP = 7'd108;

  logic [3:0]         state, state_nxt;
  logic [6:0]         count;

  logic [63:0]        a, b, z;
  logic [52:0]        a_m, b_m, z_m;
  logic signed [12:0] a_e, b_e, z_e;
  logic               a_s, b_s, z_s;
  logic               guard, round_bit, sticky;
  logic [108:0]       dividend;
  logic [52:0]        remainder;
  logic [56:0]        quotient;
`ifdef FPU_DP_DIV_DZ_FLAG_EN
  logic               dz;
`endif

  // operand classification on the unpacked fields
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, special;
  assign a_nan   = (a_e == 13'sd1024)  && (a_m[51:0] != '0);
  assign b_nan   = (b_e == 13'sd1024)  && (b_m[51:0] != '0);
  assign a_inf   = (a_e == 13'sd1024)  && (a_m[51:0] == '0);
  assign b_inf   = (b_e == 13'sd1024)  && (b_m[51:0] == '0);
  assign a_zero  = (a_e == -13'sd1023) && (a_m[51:0] == '0);
  assign b_zero  = (b_e == -13'sd1023) && (b_m[51:0] == '0);
  assign special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

  // restoring-division step: remainder < b_m before the shift, so 54 bits
  // cover the shifted value and a set MSB always implies a subtraction
  logic [53:0] rem_sh;
  logic        rem_ge;
  assign rem_sh = {remainder, dividend[108]};
  assign rem_ge = rem_sh >= {1'b0, b_m};

  logic        do_round;
  assign do_round = guard & (round_bit | sticky | z_m[0]);

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_REQ:      if (dval) state_nxt = UNPACK;
      UNPACK:        state_nxt = SPECIAL_CASES;
      SPECIAL_CASES: state_nxt = special ? OUT_RDY : NORMALISE_A;
      NORMALISE_A:   if (a_m[52]) state_nxt = NORMALISE_B;
      NORMALISE_B:   if (b_m[52]) state_nxt = DIV_INIT;
      DIV_INIT:      state_nxt = DIVIDE;
      DIVIDE:        if (count == LAST_STEP) state_nxt = DIV_DONE;
      DIV_DONE:      state_nxt = NORMALISE_1;
      NORMALISE_1:   if (z_m[52]) state_nxt = NORMALISE_2;
      NORMALISE_2:   if (!(z_e < -13'sd1022)) state_nxt = ROUND;
      ROUND:         state_nxt = PACK;
      PACK:          state_nxt = OUT_RDY;
      OUT_RDY:       state_nxt = WAIT_REQ;
      default:       state_nxt = WAIT_REQ;
    endcase
  end

  // control and output registers: the only state that needs reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= WAIT_REQ;
      count   <= '0;
      rdy     <= 1'b0;
      result  <= '0;
`ifdef FPU_DP_DIV_DZ_FLAG_EN
      dz_flag <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      rdy   <= 1'b0;
      case (state)
        DIV_INIT: count <= '0;
        DIVIDE:   count <= count + 7'd1;
        OUT_RDY: begin
          rdy     <= 1'b1;
          result  <= z;
`ifdef FPU_DP_DIV_DZ_FLAG_EN
          dz_flag <= dz;
`endif
        end
        default: ;
      endcase
    end
  end

  // datapath: every register here is written before it is read in an operation
  always_ff @(posedge clk) begin
    case (state)
      WAIT_REQ: begin
        if (dval) begin
          a <= din1;
          b <= din2;
        end
      end

      UNPACK: begin
        a_m <= {1'b0, a[51:0]};
        b_m <= {1'b0, b[51:0]};
        a_e <= $signed({2'b00, a[62:52]}) - 13'sd1023;
        b_e <= $signed({2'b00, b[62:52]}) - 13'sd1023;
        a_s <= a[63];
        b_s <= b[63];
      end

      SPECIAL_CASES: begin
`ifdef FPU_DP_DIV_DZ_FLAG_EN
        dz <= b_zero & ~(a_nan | a_inf | a_zero);
`endif
        if (a_nan | b_nan)           z <= QNAN;
        else if (a_inf & b_inf)      z <= QNAN;
        else if (a_zero & b_zero)    z <= QNAN;
        else if (a_inf)              z <= {a_s ^ b_s, 11'h7FF, 52'd0};
        else if (b_zero)             z <= {a_s ^ b_s, 11'h7FF, 52'd0};
        else if (a_zero)             z <= {a_s ^ b_s, 63'd0};
        else if (b_inf)              z <= {a_s ^ b_s, 63'd0};
        else begin
          // denormals use the minimum exponent; normals get the hidden bit
          if (a_e == -13'sd1023) a_e <= -13'sd1022;
          else                   a_m[52] <= 1'b1;
          if (b_e == -13'sd1023) b_e <= -13'sd1022;
          else                   b_m[52] <= 1'b1;
        end
      end

      NORMALISE_A: begin
        if (!a_m[52]) begin
          a_m <= {a_m[51:0], 1'b0};
          a_e <= a_e - 13'sd1;
        end
      end

      NORMALISE_B: begin
        if (!b_m[52]) begin
          b_m <= {b_m[51:0], 1'b0};
          b_e <= b_e - 13'sd1;
        end
      end

      DIV_INIT: begin
        dividend  <= {a_m, 56'd0};
        remainder <= '0;
        quotient  <= '0;
        z_e       <= a_e - b_e;
        z_s       <= a_s ^ b_s;
      end

      DIVIDE: begin
        dividend  <= {dividend[107:0], 1'b0};
        remainder <= rem_ge ? 53'(rem_sh - {1'b0, b_m}) : rem_sh[52:0];
        quotient  <= {quotient[55:0], rem_ge};
      end

      // both mantissas are normalised, so the quotient lies in (2^55, 2^57):
      // bit 56 or bit 55 is the leading one
      DIV_DONE: begin
        z_m       <= quotient[56:4];
        guard     <= quotient[3];
        round_bit <= quotient[2];
        sticky    <= (|quotient[1:0]) | (remainder != '0);
      end

      NORMALISE_1: begin
        if (!z_m[52]) begin
          z_m       <= {z_m[51:0], guard};
          guard     <= round_bit;
          round_bit <= 1'b0;
          z_e       <= z_e - 13'sd1;
        end
      end

      // gradual underflow: denormalise, keeping shifted-out bits for rounding
      NORMALISE_2: begin
        if (z_e < -13'sd1022) begin
          z_m       <= {1'b0, z_m[52:1]};
          z_e       <= z_e + 13'sd1;
          guard     <= z_m[0];
          round_bit <= guard;
          sticky    <= sticky | round_bit;
        end
      end

      // an all-ones mantissa wraps to zero; the exponent bump keeps the value
      ROUND: begin
        if (do_round) begin
          z_m <= z_m + 53'd1;
          if (&z_m) z_e <= z_e + 13'sd1;
        end
      end

      PACK: begin
        z[51:0]  <= z_m[51:0];
        z[62:52] <= 11'(z_e + 13'sd1023);
        z[63]    <= z_s;
        if ((z_e == -13'sd1022) && !z_m[52]) z[62:52] <= 11'd0;
        if (z_e > 13'sd1023) z <= {z_s, 11'h7FF, 52'd0};
      end

      default: ;
    endcase
  end

endmodule

// File: tb/tb_fpu_dp_div.sv
// tb_fpu_dp_div -- self-checking bench for fpu_dp_div.
// Reference: IEEE-754 classification rules for special operands and the
// simulator's native double division (round-to-nearest-even) otherwise.
// Latency expectations come from the documented cycle counts.

module tb_fpu_dp_div;

  localparam logic [63:0] QNAN = 64'hFFF8_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] din1, din2, result;
  logic        dval, rdy;
`ifdef FPU_DP_DIV_DZ_FLAG_EN
  logic        dz_flag;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpu_dp_div #(.QNAN(QNAN)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .din1   (din1),
    .din2   (din2),
    .dval   (dval),
    .result (result),
    .rdy    (rdy)
`ifdef FPU_DP_DIV_DZ_FLAG_EN
    ,
    .dz_flag(dz_flag)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic bit is_nan(input logic [63:0] x);
    return (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
  endfunction
  function automatic bit is_inf(input logic [63:0] x);
    return (x[62:52] == 11'h7FF) && (x[51:0] == 52'd0);
  endfunction
  function automatic bit is_zero(input logic [63:0] x);
    return x[62:0] == 63'd0;
  endfunction
  function automatic bit is_special(input logic [63:0] x);
    return is_nan(x) || is_inf(x) || is_zero(x);
  endfunction

  function automatic logic [63:0] ref_div(input logic [63:0] x, input logic [63:0] y);
    logic s;
    s = x[63] ^ y[63];
    if (is_nan(x) || is_nan(y) || (is_inf(x) && is_inf(y)) || (is_zero(x) && is_zero(y)))
      return QNAN;
    if (is_inf(x) || is_zero(y)) return {s, 11'h7FF, 52'd0};
    if (is_zero(x) || is_inf(y)) return {s, 63'd0};
    return $realtobits($bitstoreal(x) / $bitstoreal(y));
  endfunction

  function automatic logic [63:0] pick_any();
    logic [63:0] tbl [8];
    tbl = '{64'h0000_0000_0000_0000, 64'h8000_0000_0000_0000,
            64'h7FF0_0000_0000_0000, 64'hFFF0_0000_0000_0000,
            64'h7FF4_0000_0000_0001, 64'h0000_0000_0000_0001,
            64'h000F_FFFF_FFFF_FFFF, 64'h7FEF_FFFF_FFFF_FFFF};
    if ($urandom_range(0, 3) == 0) return tbl[$urandom_range(0, 7)];
    return {$urandom, $urandom};
  endfunction

  // normal operands with exponents that keep the quotient well inside range
  function automatic logic [63:0] pick_mod();
    return {1'($urandom_range(0, 1)), 11'($urandom_range(900, 1100)),
            20'($urandom), 32'($urandom)};
  endfunction

  // Issue one request at the current time (#1 after an edge) and wait for rdy.
  // lat < 0 skips the latency check.
  task automatic do_div(input logic [63:0] x, input logic [63:0] y, input int lat,
                        input string tag);
    logic [63:0] expr;
    int n;
    bit got;
    expr = ref_div(x, y);
    din1 = x;
    din2 = y;
    dval = 1'b1;
    @(posedge clk); #1;
    dval = 1'b0;
    din1 = {$urandom, $urandom};
    din2 = {$urandom, $urandom};
    chk({tag, ".rdy_low"}, {63'd0, rdy}, 64'd0);
    n = 0;
    got = 1'b0;
    while (!got && n < 3000) begin
      @(posedge clk); n++; #1;
      if (rdy) got = 1'b1;
      else if (n == 10) dval = 1'b1;   // must be ignored while busy
      else if (n == 11) dval = 1'b0;
    end
    dval = 1'b0;
    chk({tag, ".done"}, {63'd0, got}, 64'd1);
    if (got) begin
      if (lat >= 0) chk({tag, ".lat"}, 64'(n), 64'(lat));
      chk({tag, ".res"}, result, expr);
`ifdef FPU_DP_DIV_DZ_FLAG_EN
      chk({tag, ".dz"}, {63'd0, dz_flag},
          {63'd0, is_zero(y) && !is_special(x)});
`endif
    end
  endtask

  initial begin
    logic [63:0] x, y;
    bit seen;
    rst_n = 1'b0;
    dval  = 1'b0;
    din1  = '0;
    din2  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.rdy", {63'd0, rdy}, 64'd0);
    chk("reset.result", result, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // directed cases
    do_div(64'h4018_0000_0000_0000, 64'h4000_0000_0000_0000, 120, "six_by_two");
    do_div(64'h3FF0_0000_0000_0000, 64'h4008_0000_0000_0000, 121, "one_by_three");
    do_div(64'h3FF0_0000_0000_0000, 64'h0000_0000_0000_0000, 3, "one_by_zero");
    do_div(64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 3, "zero_by_zero");
    do_div(64'hFFF0_0000_0000_0000, 64'h4000_0000_0000_0000, 3, "ninf_by_two");
    do_div(64'h7FF0_0000_0000_0000, 64'hFFF0_0000_0000_0000, 3, "inf_by_inf");
    do_div(64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 3, "nzero_by_two");
    do_div(64'h4000_0000_0000_0000, 64'hFFF0_0000_0000_0000, 3, "two_by_ninf");
    do_div(64'h7FEF_FFFF_FFFF_FFFF, 64'h3FE0_0000_0000_0000, 120, "overflow");
    // 52 dividend normalise shifts + 53 underflow shifts on top of 120
    do_div(64'h0000_0000_0000_0001, 64'h4000_0000_0000_0000, 225, "denorm_tie");

    // result holds after the pulse
    repeat (5) @(posedge clk);
    #1;
    chk("hold.rdy", {63'd0, rdy}, 64'd0);
    chk("hold.result", result, 64'd0);
    do_div(64'h4018_0000_0000_0000, 64'h4000_0000_0000_0000, 120, "refill");
    repeat (4) @(posedge clk);
    #1;
    chk("hold2.result", result, 64'h4008_0000_0000_0000);

    // reset in the middle of a divide
    din1 = 64'h4000_0000_0000_0000;
    din2 = 64'h3FF8_0000_0000_0000;
    dval = 1'b1;
    @(posedge clk); #1;
    dval = 1'b0;
    repeat (49) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort.rdy", {63'd0, rdy}, 64'd0);
    chk("abort.result", result, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (150) begin
      @(posedge clk); #1;
      if (rdy) seen = 1'b1;
    end
    chk("abort.no_rdy", {63'd0, seen}, 64'd0);
    do_div(64'h3FF0_0000_0000_0000, 64'h4008_0000_0000_0000, 121, "after_abort");

    // random normal operands: latency follows the mantissa comparison
    for (int i = 0; i < 20; i++) begin
      x = pick_mod();
      y = pick_mod();
      do_div(x, y, (x[51:0] >= y[51:0]) ? 120 : 121, $sformatf("mod%0d", i));
    end

    // random full-range operands, including specials and denormals
    for (int i = 0; i < 30; i++) begin
      x = pick_any();
      y = pick_any();
      do_div(x, y, (is_special(x) || is_special(y)) ? 3 : -1, $sformatf("any%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
